// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and one-hot helper for the register-select path
package cpu_pkg;

   localparam int NUM_REGS_DEF = 16;
   localparam int IR_W_DEF     = 32;
   localparam int RA_LSB_DEF   = 23;
   localparam int RB_LSB_DEF   = 19;
   localparam int RC_LSB_DEF   = 15;

   // Widest register file the unit supports; onehot() is sized for it and callers slice.
   localparam int MAX_REGS  = 64;
   localparam int MAX_SEL_W = 6;

   function automatic logic [MAX_REGS-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
      logic [MAX_REGS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - binary to one-hot decoder with enable
module onehot_dec #(
   parameter int SEL_W = 4
) (
   input  logic [SEL_W-1:0]      sel,
   input  logic                  en,
   output logic [(2**SEL_W)-1:0] dec
);

   always_comb begin
      dec = '0;
      if (en) begin
         dec[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_select_decode.sv
// rtl/reg_select_decode.sv - IR latch, register field select, enable decode and write-pending scoreboard
module reg_select_decode
   import cpu_pkg::*;
#(
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int IR_W     = IR_W_DEF,
   parameter  int RA_LSB   = RA_LSB_DEF,
   parameter  int RB_LSB   = RB_LSB_DEF,
   parameter  int RC_LSB   = RC_LSB_DEF,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                ir_load,
   input  logic [IR_W-1:0]     ir_bus,
   input  logic                gra,
   input  logic                grb,
   input  logic                grc,
   input  logic                rin,
   input  logic                rout,
   input  logic                baout,
   input  logic                reserve,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [NUM_REGS-1:0] reg_out,
   output logic                r0_zero,
   output logic [SEL_W-1:0]    sel_idx,
   output logic                hazard,
   output logic [NUM_REGS-1:0] pending
);

   logic [IR_W-1:0]     ir_q;
   logic [SEL_W-1:0]    sel_hold;
   logic [SEL_W-1:0]    ra;
   logic [SEL_W-1:0]    rb;
   logic [SEL_W-1:0]    rc;
   logic [SEL_W-1:0]    idx;
   logic                any_gr;
   logic                idx_is_r0;
   logic                dec_en;
   logic [NUM_REGS-1:0] dec_out;
   logic [MAX_REGS-1:0] sb_full;
   logic [NUM_REGS-1:0] sb_mask;
   logic                unused_ir;
   logic                unused_mask;

   assign ra = ir_q[RA_LSB +: SEL_W];
   assign rb = ir_q[RB_LSB +: SEL_W];
   assign rc = ir_q[RC_LSB +: SEL_W];

   assign any_gr = gra | grb | grc;

   always_comb begin
      idx = sel_hold;
      if (gra) begin
         idx = ra;
      end else if (grb) begin
         idx = rb;
      end else if (grc) begin
         idx = rc;
      end
   end

   assign idx_is_r0 = (idx == '0);

   // baout outranks rout, so a baout aimed at R0 must suppress the decode even if rout is also high.
   always_comb begin
      dec_en = 1'b0;
      if (rin) begin
         dec_en = 1'b1;
      end else if (baout) begin
         dec_en = ~idx_is_r0;
      end else if (rout) begin
         dec_en = 1'b1;
      end
   end

   onehot_dec #(
      .SEL_W (SEL_W)
   ) u_dec (
      .sel (idx),
      .en  (dec_en),
      .dec (dec_out)
   );

   assign sb_full = onehot(MAX_SEL_W'(idx));
   assign sb_mask = sb_full[NUM_REGS-1:0];

   assign unused_ir   = ^ir_q;
   assign unused_mask = ^sb_full;

   always_ff @(posedge clk) begin
      if (clr) begin
         ir_q     <= '0;
         sel_hold <= '0;
         pending  <= '0;
         reg_in   <= '0;
         reg_out  <= '0;
         r0_zero  <= 1'b0;
         sel_idx  <= '0;
         hazard   <= 1'b0;
      end else begin
         if (ir_load) begin
            ir_q <= ir_bus;
         end
         if (any_gr) begin
            sel_hold <= idx;
         end
         sel_idx <= idx;

         reg_in  <= rin ? dec_out : '0;
         reg_out <= (!rin && (baout || rout)) ? dec_out : '0;
         r0_zero <= !rin && baout && idx_is_r0;

         hazard <= (rout | baout) & ~rin & pending[idx];

         // Set is applied after clear so reserve wins over a same-cycle rin.
         pending <= (pending & ~(rin ? sb_mask : '0)) | (reserve ? sb_mask : '0);
      end
   end

endmodule
